// File: rtl/mmio_uart_tx_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// XLEN and mem_write_control_t mirror the data-memory stage's MMIO bundle.
package mmio_uart_tx_pkg;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] value;
    logic [1:0]      width;
    logic            enable;
  } mem_write_control_t;

  localparam logic [3:0] UART_TXDATA_OFF = 4'h0;
  localparam logic [3:0] UART_STATUS_OFF = 4'h4;
  localparam logic [3:0] UART_BAUD_OFF   = 4'h8;
  localparam logic [3:0] UART_CTRL_OFF   = 4'hC;

  localparam int unsigned STATUS_FULL_BIT  = 0;
  localparam int unsigned STATUS_EMPTY_BIT = 1;
  localparam int unsigned STATUS_BUSY_BIT  = 2;
  localparam int unsigned STATUS_OVF_BIT   = 3;
  localparam int unsigned STATUS_COUNT_LSB = 8;
  localparam int unsigned STATUS_COUNT_W   = 8;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// MMIO request bundle from the data-memory stage plus the combinational read-data return.
interface mmio_uart_tx_if;
  import mmio_uart_tx_pkg::*;

  mem_write_control_t mmio_control;
  logic [XLEN-1:0]    mmio_r_data;

  modport master (output mmio_control, input mmio_r_data);
  modport slave  (input mmio_control, output mmio_r_data);
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO with registered count/full/empty and a show-ahead read port.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_d;
  logic             do_push, do_pop;

  // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    count_d = count;
    if (do_push && !do_pop)      count_d = count + CW'(1);
    else if (do_pop && !do_push) count_d = count - CW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_d;
      full  <= (count_d == CW'(DEPTH));
      empty <= (count_d == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata_c = mem[rd_ptr];

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO, status and baud-divider registers.
// Optional CTRL register and tx_irq output enabled by defining MMIO_UART_TX_IRQ_EN.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [XLEN-1:0] BASE_ADDR        = 32'h0003_0000,
  parameter int unsigned     FIFO_DEPTH       = 8,
  parameter logic [15:0]     DEFAULT_BAUD_DIV = 16'd868
) (
  input  logic          clock,
  input  logic          reset,
  mmio_uart_tx_if.slave mmio,
  output logic          uart_tx
`ifdef MMIO_UART_TX_IRQ_EN
  ,
  output logic          tx_irq
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  uart_tx_state_t state_q, state_d;
  logic [15:0]    cnt_q, cnt_d, div_q, div_d, baud_q, baud_d, eff_div_c;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d, ovf_q, ovf_d, bit_done_c;
  logic           irq_en_q, irq_en_d, irq_q, irq_d;

  logic [XLEN-1:0]  rel_addr_c;
  logic [3:0]       reg_off_c;
  logic             hit_c, wr_c, wr_txdata_c, wr_status_c, wr_baud_c, wr_ctrl_c;
  logic             fifo_pop_c, fifo_full, fifo_empty;
  logic [7:0]       fifo_rdata_c;
  logic [CNT_W-1:0] fifo_count;
  logic             unused_bits;

  // Address decode: 16-byte window, word-aligned registers only; write width is ignored.
  assign rel_addr_c  = mmio.mmio_control.addr - BASE_ADDR;
  assign reg_off_c   = rel_addr_c[3:0];
  assign hit_c       = (rel_addr_c < XLEN'(16)) && (mmio.mmio_control.addr[1:0] == 2'b00);
  assign wr_c        = mmio.mmio_control.enable && hit_c;
  assign wr_txdata_c = wr_c && (reg_off_c == UART_TXDATA_OFF);
  assign wr_status_c = wr_c && (reg_off_c == UART_STATUS_OFF);
  assign wr_baud_c   = wr_c && (reg_off_c == UART_BAUD_OFF);
  assign wr_ctrl_c   = wr_c && (reg_off_c == UART_CTRL_OFF);
  assign unused_bits = ^{mmio.mmio_control.width, mmio.mmio_control.value[XLEN-1:16], wr_ctrl_c};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (wr_txdata_c),
    .pop     (fifo_pop_c),
    .wdata   (mmio.mmio_control.value[7:0]),
    .rdata_c (fifo_rdata_c),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign eff_div_c  = (baud_q == '0) ? 16'd1 : baud_q;
  assign bit_done_c = (cnt_q == div_q - 16'd1);

  // Serializer next-state and register-file next values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    div_d      = div_q;
    fifo_pop_c = 1'b0;
    tx_d       = 1'b1;
    baud_d     = baud_q;
    ovf_d      = ovf_q;
    irq_en_d   = irq_en_q;
    irq_d      = 1'b0;

    unique case (state_q)
      UART_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop_c = 1'b1;
          shift_d    = fifo_rdata_c;
          div_d      = eff_div_c;
          cnt_d      = '0;
          state_d    = UART_START;
        end
      end
      UART_START: begin
        if (bit_done_c) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = UART_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      UART_DATA: begin
        if (bit_done_c) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = UART_STOP;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      UART_STOP: begin
        if (bit_done_c) begin
          cnt_d = '0;
          // Chain straight into the next frame to avoid an idle gap.
          if (!fifo_empty) begin
            fifo_pop_c = 1'b1;
            shift_d    = fifo_rdata_c;
            div_d      = eff_div_c;
            state_d    = UART_START;
          end else begin
            state_d = UART_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = UART_IDLE;
    endcase

    unique case (state_d)
      UART_START: tx_d = 1'b0;
      UART_DATA:  tx_d = shift_d[0];
      default:    tx_d = 1'b1;
    endcase

    if (wr_baud_c) baud_d = mmio.mmio_control.value[15:0];
    if (wr_txdata_c && fifo_full && !fifo_pop_c) ovf_d = 1'b1;
    else if (wr_status_c && mmio.mmio_control.value[STATUS_OVF_BIT]) ovf_d = 1'b0;

`ifdef MMIO_UART_TX_IRQ_EN
    if (wr_ctrl_c) irq_en_d = mmio.mmio_control.value[0];
    irq_d = irq_en_q && fifo_empty && (state_q == UART_IDLE);
`else
    irq_en_d = 1'b0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= UART_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      div_q    <= '0;
      tx_q     <= 1'b1;
      baud_q   <= DEFAULT_BAUD_DIV;
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      div_q    <= div_d;
      tx_q     <= tx_d;
      baud_q   <= baud_d;
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign uart_tx = tx_q;
`ifdef MMIO_UART_TX_IRQ_EN
  assign tx_irq = irq_q;
`endif

  // Side-effect-free read mux.
  always_comb begin
    mmio.mmio_r_data = '0;
    if (hit_c) begin
      unique case (reg_off_c)
        UART_STATUS_OFF: begin
          mmio.mmio_r_data[STATUS_FULL_BIT]  = fifo_full;
          mmio.mmio_r_data[STATUS_EMPTY_BIT] = fifo_empty;
          mmio.mmio_r_data[STATUS_BUSY_BIT]  = (state_q != UART_IDLE);
          mmio.mmio_r_data[STATUS_OVF_BIT]   = ovf_q;
          mmio.mmio_r_data[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(fifo_count);
        end
        UART_BAUD_OFF: mmio.mmio_r_data[15:0] = baud_q;
        UART_CTRL_OFF: mmio.mmio_r_data[0] = irq_en_q;
        default: ;
      endcase
    end
  end

endmodule
